rr_sel_arbiter: RTL
===================

# rr_sel_arbiter

Round-robin arbiter driving the select input of the generalized `mux`. It accepts up to 2**SEL_BITS requesters and picks one fairly. It holds the binary select stable while the muxed word is offered downstream under a valid/ready handshake, and returns a one-cycle acknowledge to the winning requester. It sits between the requester array and the `mux` instance: `sel` feeds `mux.sel`, and the consumer takes `mux.out` qualified by `out_valid`.

## Interface
- SEL_BITS, 3, select width; number of requesters N = 2**SEL_BITS; legal range 1..5
- WIDTH, 8, data width of the companion `mux`; used here only for assertion checks, no datapath inside
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  N  per-requester request; held high until that requester's `ack`
- lock  input  1  keep current grant after a transfer (used only with RR_ARB_LOCK_EN)
- out_ready  input  1  consumer accepts the current word
- sel  output  SEL_BITS  binary index of the granted requester, to `mux.sel`
- grant  output  N  one-hot copy of `sel`; all-zero when not granting
- out_valid  output  1  `mux.out` carries a granted word
- ack  output  N  one-hot transfer pulse, equal to grant & {N{out_valid & out_ready}}; combinational

## Operation
- Registered state:
  - FSM: IDLE, GRANT
  - rotation pointer `ptr` [SEL_BITS-1:0]
  - `sel` register
- Reset values: state=IDLE, ptr=0, sel=0, grant=0, out_valid=0; ack=0 as a consequence.
- IDLE:
  - If req==0, stay.
  - Otherwise, winner = first index i scanning ptr, ptr+1, …, wrapping mod N, with req[i]=1.
  - Register sel=winner and grant=1<<winner. Go to GRANT.
- GRANT:
  - out_valid=1. sel and grant are frozen.
  - req changes from any requester, including deassertion by the granted one, are ignored until transfer.
- Transfer happens when out_valid & out_ready. On transfer:
  - ack[sel] pulses for that cycle.
  - ptr <= sel+1, wrapping N-1 -> 0.
  - State -> IDLE; grant and out_valid drop at the same edge.
  - sel keeps its last value in IDLE, so the mux output stays stable but is unqualified.
- Fairness: a continuously requesting source waits at most N-1 transfers.
- Simultaneous events:
  - A transfer and new requests in the same cycle: the new requests are evaluated in the following IDLE cycle.
  - Reset asserted during GRANT: the word is dropped, no ack is issued, and the requester must re-request.

## Timing
- Request-to-valid latency: req sampled high at edge k in IDLE -> out_valid=1 after edge k.
- Throughput: at most one transfer per 2 cycles, because there is one mandatory IDLE cycle between grants. Exception: the lock path below.
- ack is combinational from out_ready within the transfer cycle. A requester may change data or deassert req only after the edge that ends the ack cycle.
- out_ready is ignored while out_valid=0.
- sel changes only on the IDLE->GRANT edge and on reset.

## Configuration
- RR_ARB_LOCK_EN defined:
  - In GRANT, a transfer with lock=1 stays in GRANT with the same sel and grant. out_valid stays 1 and ptr is not advanced.
  - The locked requester must present its next word at the edge following its ack. This allows back-to-back bursts at 1 word/cycle.
  - A transfer with lock=0 behaves as the base design.
- RR_ARB_LOCK_EN undefined: the lock input is ignored, and every transfer returns to IDLE.

## Test plan
Bench configuration: SEL_BITS=2 (N=4), WIDTH=8.
- Reset: with req=4'b1111, assert reset mid-cycle -> out_valid, grant, ack become 0 immediately. Release reset; first grant is sel=0.
- Rotation: hold req=4'b1111 with out_ready=1 for 8 transfers -> sel sequence 0,1,2,3,0,1,2,3, with out_valid high on alternate cycles.
- Wrap and skip: ptr=3 after a grant to 2, then req=4'b0010 -> sel=1. Next req=4'b1001 -> sel=3 (scan from 2).
- Backpressure: grant req[2] with out_ready=0 for 5 cycles while req changes -> sel=2 and out_valid=1 held, ack=0. out_ready=1 -> ack=4'b0100 for exactly 1 cycle.
- Reset mid-GRANT: out_valid=1 at sel=1, assert reset -> no ack[1] pulse, state IDLE, ptr=0.
- Lock (RR_ARB_LOCK_EN): req[3]=1 and lock=1 for 3 transfers, then lock=0 -> 4 consecutive cycles of out_valid=1 at sel=3 with ack[3] each cycle. Next grant scans from 0.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter that drives the select of a companion mux and offers the
// muxed word under valid/ready. Optional burst lock: define RR_ARB_LOCK_EN.
module rr_sel_arbiter #(
  parameter int SEL_BITS = 3,
  parameter int WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [(1<<SEL_BITS)-1:0] req,
  input  logic                     lock,
  input  logic                     out_ready,
  output logic [SEL_BITS-1:0]      sel,
  output logic [(1<<SEL_BITS)-1:0] grant,
  output logic                     out_valid,
  output logic [(1<<SEL_BITS)-1:0] ack,
  output logic                     state_dbg
);

  localparam int N = 1 << SEL_BITS;

  // Handshake: a word moves when out_valid & out_ready are both high at a
  // rising edge; out_valid never drops without a transfer (except on reset),
  // and out_ready is don't-care while out_valid is low.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [SEL_BITS-1:0] ptr, ptr_next;
  logic [SEL_BITS-1:0] sel_next;
  logic [SEL_BITS-1:0] winner;
  logic [SEL_BITS-1:0] cand;
  logic                found;
  logic                xfer;

  // Scan from ptr upward; index arithmetic wraps naturally since N = 2**SEL_BITS.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + SEL_BITS'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign out_valid = (state == GRANT);
  assign grant     = out_valid ? (N'(1) << sel) : '0;
  assign xfer      = out_valid & out_ready;
  assign ack       = grant & {N{xfer}};
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = GRANT;
          sel_next   = winner;
        end
      end
      GRANT: begin
        if (xfer) begin
`ifdef RR_ARB_LOCK_EN
          if (!lock) begin
            state_next = IDLE;
            ptr_next   = sel + SEL_BITS'(1);
          end
`else
          state_next = IDLE;
          ptr_next   = sel + SEL_BITS'(1);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifndef RR_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = lock;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      sel   <= sel_next;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (SEL_BITS >= 1 && SEL_BITS <= 5 && WIDTH >= 1);
      assert ($onehot0(grant));
      assert ($onehot0(ack));
    end
  end

endmodule
